// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square root.
// Every width is derived from the operand width W.
package isqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        STEP = 3'd2,
        DONE = 3'd3
    } isqrt_state_e;

    // root width
    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    // remainder and odd-step width
    function automatic int rem_w(input int w);
        return w / 2 + 1;
    endfunction

    // square accumulator width; holds up to 2^W
    function automatic int sq_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// Operand and result handshake bundle for isqrt_seq.
// The master drives operands and accepts results.
interface isqrt_seq_if #(
    parameter int W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [W-1:0]     x_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W/2-1:0]   root_o;
    logic [W/2:0]     rem_o;

    modport master (
        output in_valid_i,
        output x_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  root_o,
        input  rem_o
    );

    modport slave (
        input  in_valid_i,
        input  x_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output root_o,
        output rem_o
    );
endinterface

// File: rtl/isqrt_seq_ctrl.sv
// Controller for isqrt_seq: state machine, handshake gating,
// flush and enable handling. Emits load/step/capture strobes.
module isqrt_seq_ctrl
    import isqrt_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic enb_i,
    input  logic flush_i,
    input  logic in_valid_i,
    input  logic out_ready_i,
    input  logic le_i,
    input  logic zero_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic busy_o,
    output logic load_o,
    output logic step_o,
    output logic cap_o
);

    isqrt_state_e state_q;
    isqrt_state_e state_d;

    assign in_ready_o  = (state_q == IDLE) && enb_i;
    assign out_valid_o = (state_q == DONE) && enb_i;
    assign busy_o      = (state_q != IDLE);

    // next state and datapath strobes; flush overrides any progress
    always_comb begin
        state_d = state_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        cap_o   = 1'b0;
        if (enb_i && !flush_i) begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        load_o  = 1'b1;
                        state_d = zero_i ? DONE : CMP;
                    end
                end
                CMP: begin
                    if (le_i) begin
                        state_d = STEP;
                    end else begin
                        cap_o   = 1'b1;
                        state_d = DONE;
                    end
                end
                STEP: begin
                    step_o  = 1'b1;
                    state_d = CMP;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root by odd-number summation.
// Tracks s=(r+1)^2 and d=2r+1 so each step needs only adds.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int W      = 16,
    parameter bit REM_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enb_i,
    input  logic        flush_i,
    isqrt_seq_if.slave  bus,
    output logic        busy_o
);

    localparam int RW  = root_w(W);
    localparam int RMW = rem_w(W);
    localparam int SW  = sq_w(W);

    logic [W-1:0]   x_q;
    logic [RW-1:0]  r_q;
    logic [SW-1:0]  s_q;
    logic [RMW-1:0] d_q;
    logic [RW-1:0]  root_q;
    logic [RMW-1:0] rem_q;

    logic           le;
    logic           zero;
    logic           load;
    logic           step;
    logic           cap;
    logic [RMW-1:0] rem_d;

    assign le   = (s_q <= {1'b0, x_q});
    assign zero = (bus.x_i == '0);

    // x + d - s equals x - r^2 and always fits RMW bits,
    // so modular arithmetic in that width is exact
    assign rem_d = RMW'(x_q) + d_q - RMW'(s_q);

    assign bus.root_o = root_q;
    assign bus.rem_o  = rem_q;

    isqrt_seq_ctrl u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enb_i       (enb_i),
        .flush_i     (flush_i),
        .in_valid_i  (bus.in_valid_i),
        .out_ready_i (bus.out_ready_i),
        .le_i        (le),
        .zero_i      (zero),
        .in_ready_o  (bus.in_ready_o),
        .out_valid_o (bus.out_valid_o),
        .busy_o      (busy_o),
        .load_o      (load),
        .step_o      (step),
        .cap_o       (cap)
    );

    // datapath: load operand, advance the odd sum, capture result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            r_q    <= '0;
            s_q    <= '0;
            d_q    <= '0;
            root_q <= '0;
            rem_q  <= '0;
        end else begin
            if (load) begin
                x_q <= bus.x_i;
                r_q <= '0;
                s_q <= SW'(1);
                d_q <= RMW'(1);
                if (zero) begin
                    root_q <= '0;
                    rem_q  <= '0;
                end
            end
            if (step) begin
                r_q <= r_q + RW'(1);
                d_q <= d_q + RMW'(2);
                s_q <= s_q + SW'(d_q) + SW'(2);
            end
            if (cap) begin
                root_q <= r_q;
                rem_q  <= REM_EN ? rem_d : '0;
            end
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed self-checking bench for isqrt_seq at W=16.
// Expected roots, remainders and latencies are hand-computed.
module tb_isqrt_seq;

    logic clk = 1'b0;
    logic rst;
    logic enb;
    logic flush;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;

    isqrt_seq_if #(.W(16)) bus ();

    isqrt_seq #(.W(16), .REM_EN(1'b1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .enb_i   (enb),
        .flush_i (flush),
        .bus     (bus),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // run one operation; optional 3-cycle enable stall after stall_at edges
    task automatic run_op(input string tag, input int x, input int er,
                          input int erem, input int elat,
                          input int stall_at, input int hold);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, int'(bus.in_ready_o), 1);
        bus.in_valid_i = 1'b1;
        bus.x_i        = 16'(x);
        tick();
        bus.in_valid_i = 1'b0;
        bus.x_i        = 16'hFFFF;
        lat = 1;
        while (!bus.out_valid_o && lat < 2000) begin
            if (lat == stall_at) begin
                enb = 1'b0;
                repeat (3) begin
                    tick();
                    lat++;
                end
                enb = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_root"}, int'(bus.root_o), er);
        chk({tag, "_rem"}, int'(bus.rem_o), erem);
        repeat (hold) begin
            tick();
            chk({tag, "_hold_root"}, int'(bus.root_o), er);
            chk({tag, "_hold_rem"}, int'(bus.rem_o), erem);
            chk({tag, "_hold_vld"}, int'(bus.out_valid_o), 1);
            chk({tag, "_hold_irdy"}, int'(bus.in_ready_o), 0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    // start x=1000, abort it with flush or reset, watch for stray results
    task automatic abort_op(input string tag, input bit use_rst);
        int seen;
        bus.in_valid_i = 1'b1;
        bus.x_i        = 16'd1000;
        tick();
        bus.in_valid_i = 1'b0;
        repeat (5) tick();
        chk({tag, "_busy_pre"}, int'(busy), 1);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_irdy"}, int'(bus.in_ready_o), 1);
        seen = 0;
        repeat (80) begin
            if (bus.out_valid_o) seen = 1;
            tick();
        end
        chk({tag, "_no_vld"}, seen, 0);
    endtask

    initial begin
        rst             = 1'b1;
        enb             = 1'b0;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.x_i         = '0;
        bus.out_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_irdy_enb0", int'(bus.in_ready_o), 0);
        enb = 1'b1;
        #1;
        chk("rst_irdy", int'(bus.in_ready_o), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vld", int'(bus.out_valid_o), 0);
        chk("rst_root", int'(bus.root_o), 0);
        chk("rst_rem", int'(bus.rem_o), 0);
        rst = 1'b0;
        tick();

        run_op("x0", 0, 0, 0, 1, -1, 0);
        run_op("x15", 15, 3, 6, 8, -1, 0);
        run_op("x16", 16, 4, 0, 10, -1, 0);
        run_op("x65535", 65535, 255, 510, 512, -1, 0);
        run_op("x15h", 15, 3, 6, 8, -1, 5);
        run_op("x100", 100, 10, 0, 22, -1, 0);
        run_op("x50s", 50, 7, 1, 19, 4, 0);
        run_op("x1", 1, 1, 0, 4, -1, 0);
        run_op("x255", 255, 15, 30, 32, -1, 0);

        abort_op("flush", 1'b0);
        run_op("x2f", 2, 1, 1, 4, -1, 0);
        abort_op("reset", 1'b1);
        run_op("x2r", 2, 1, 1, 4, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
